// File: rtl/conv_layer_pkg.sv
// conv_layer_pkg: shared types and constants for the convolution layer sequencer
// and the S00_AXI register file that feeds it.
package conv_layer_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT = 2;
    localparam int STRIDE_W = 2;
    localparam logic [STRIDE_W-1:0] STRIDE_LOG2_MAX = 2'd2;
    localparam int CFG_DIM_W = 10;
    localparam int CFG_NF_W = 8;
    localparam int CFG_ADDR_W = 32;
    typedef struct packed {
        logic [CFG_DIM_W-1:0]  in_w;
        logic [CFG_DIM_W-1:0]  in_h;
        logic [3:0]            filt;
        logic [STRIDE_W-1:0]   stride_log2;
        logic [CFG_NF_W-1:0]   num_filt;
        logic [CFG_ADDR_W-1:0] in_base;
        logic [CFG_ADDR_W-1:0] out_base;
    } layer_cfg_t;
    function automatic logic stride_ok(input logic [STRIDE_W-1:0] s);
        return s <= STRIDE_LOG2_MAX;
    endfunction
endpackage

// File: rtl/conv_layer_loop_cnt.sv
// conv_layer_loop_cnt: filter/row/col nested counters with incremental
// input and output byte addresses (adders only, no multiplier).
module conv_layer_loop_cnt
    import conv_layer_pkg::*;
#(
    parameter int DIM_W  = 10,
    parameter int NF_W   = 8,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [DIM_W-1:0]    in_w_i,
    input  logic [DIM_W-1:0]    out_w_i,
    input  logic [DIM_W-1:0]    out_h_i,
    input  logic [NF_W-1:0]     num_filt_i,
    input  logic [STRIDE_W-1:0] stride_log2_i,
    input  logic [ADDR_W-1:0]   in_base_i,
    input  logic [ADDR_W-1:0]   out_base_i,
    output logic [NF_W-1:0]     filt_o,
    output logic [DIM_W-1:0]    row_o,
    output logic [DIM_W-1:0]    col_o,
    output logic [ADDR_W-1:0]   in_addr_o,
    output logic [ADDR_W-1:0]   out_addr_o,
    output logic                last_o
);
    logic [NF_W-1:0]   filt_q, filt_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d, row_addr_q, row_addr_d, out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] col_step, row_step;
    logic              col_last, row_last, filt_last;

    assign col_step  = ADDR_W'(BYTES_PER_WORD) << stride_log2_i;
    assign row_step  = (ADDR_W'(in_w_i) << stride_log2_i) << WORD_SHIFT;
    assign col_last  = col_q == out_w_i - DIM_W'(1);
    assign row_last  = row_q == out_h_i - DIM_W'(1);
    assign filt_last = filt_q == num_filt_i - NF_W'(1);

    // row_addr_q tracks column 0 of the current row so a row step never needs to undo column steps
    always_comb begin
        filt_d     = filt_q;
        row_d      = row_q;
        col_d      = col_q;
        in_addr_d  = in_addr_q;
        row_addr_d = row_addr_q;
        out_addr_d = out_addr_q;
        if (load_i) begin
            filt_d     = '0;
            row_d      = '0;
            col_d      = '0;
            in_addr_d  = in_base_i;
            row_addr_d = in_base_i;
            out_addr_d = out_base_i;
        end else if (step_i) begin
            out_addr_d = out_addr_q + ADDR_W'(BYTES_PER_WORD);
            if (!col_last) begin
                col_d     = col_q + DIM_W'(1);
                in_addr_d = in_addr_q + col_step;
            end else if (!row_last) begin
                col_d      = '0;
                row_d      = row_q + DIM_W'(1);
                row_addr_d = row_addr_q + row_step;
                in_addr_d  = row_addr_q + row_step;
            end else begin
                col_d      = '0;
                row_d      = '0;
                filt_d     = filt_last ? '0 : filt_q + NF_W'(1);
                in_addr_d  = in_base_i;
                row_addr_d = in_base_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            in_addr_q  <= '0;
            row_addr_q <= '0;
            out_addr_q <= '0;
        end else begin
            filt_q     <= filt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            in_addr_q  <= in_addr_d;
            row_addr_q <= row_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign filt_o     = filt_q;
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign in_addr_o  = in_addr_q;
    assign out_addr_o = out_addr_q;
    assign last_o     = filt_last & row_last & col_last;
endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: validates a latched layer config and issues one command
// per output element, capping commands in flight and reporting busy/done/errors.
module conv_layer_sequencer
    import conv_layer_pkg::*;
#(
    parameter int DIM_W     = 10,
    parameter int NF_W      = 8,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic [DIM_W-1:0]    cfg_in_w,
    input  logic [DIM_W-1:0]    cfg_in_h,
    input  logic [3:0]          cfg_filt,
    input  logic [STRIDE_W-1:0] cfg_stride_log2,
    input  logic [NF_W-1:0]     cfg_num_filt,
    input  logic [ADDR_W-1:0]   cfg_in_base,
    input  logic [ADDR_W-1:0]   cfg_out_base,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [NF_W-1:0]     cmd_filt,
    output logic [DIM_W-1:0]    cmd_row,
    output logic [DIM_W-1:0]    cmd_col,
    output logic [ADDR_W-1:0]   cmd_in_addr,
    output logic [ADDR_W-1:0]   cmd_out_addr,
    input  logic                dp_done,
    output logic                busy,
    output logic                done,
    output logic                err_cfg,
    output logic                err_ovf
);
    localparam int OW = 4;

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    in_w_q, in_h_q;
    logic [3:0]          filt_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [NF_W-1:0]     num_filt_q;
    logic [ADDR_W-1:0]   in_base_q, out_base_q;
    logic [OW-1:0]       outst_q, outst_d;
    logic                err_cfg_q, err_cfg_d, err_ovf_q, err_ovf_d;
    logic [DIM_W-1:0]    k_ext, out_w, out_h;
    logic                cfg_bad, accept, last, launch;

    assign launch  = (state_q == ST_IDLE) && start;
    assign k_ext   = DIM_W'(filt_q);
    assign cfg_bad = (filt_q == 4'd0) || (k_ext > in_w_q) || (k_ext > in_h_q) ||
                     (num_filt_q == '0) || !stride_ok(stride_q);
    assign out_w   = ((in_w_q - k_ext) >> stride_q) + DIM_W'(1);
    assign out_h   = ((in_h_q - k_ext) >> stride_q) + DIM_W'(1);

    assign cmd_valid = (state_q == ST_ISSUE) && (outst_q < OW'(MAX_OUTST));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state_q != ST_IDLE;
    assign done      = state_q == ST_DONE;
    assign err_cfg   = err_cfg_q;
    assign err_ovf   = err_ovf_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CHECK : ST_IDLE;
            ST_CHECK: state_d = cfg_bad ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_d = (accept && last) ? ST_DRAIN : ST_ISSUE;
            ST_DRAIN: state_d = (outst_q == '0) ? ST_DONE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // a completion with nothing in flight is flagged but otherwise dropped; idle completions are stale
    always_comb begin
        outst_d   = (accept && !dp_done) ? outst_q + OW'(1) :
                    (dp_done && !accept && outst_q != '0) ? outst_q - OW'(1) : outst_q;
        err_cfg_d = launch ? 1'b0 : ((state_q == ST_CHECK) && cfg_bad) ? 1'b1 : err_cfg_q;
        err_ovf_d = launch ? 1'b0 :
                    (busy && dp_done && !accept && outst_q == '0) ? 1'b1 : err_ovf_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            outst_q    <= '0;
            err_cfg_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            in_w_q     <= '0;
            in_h_q     <= '0;
            filt_q     <= '0;
            stride_q   <= '0;
            num_filt_q <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
        end else begin
            state_q   <= state_d;
            outst_q   <= outst_d;
            err_cfg_q <= err_cfg_d;
            err_ovf_q <= err_ovf_d;
            if (launch) begin
                in_w_q     <= cfg_in_w;
                in_h_q     <= cfg_in_h;
                filt_q     <= cfg_filt;
                stride_q   <= cfg_stride_log2;
                num_filt_q <= cfg_num_filt;
                in_base_q  <= cfg_in_base;
                out_base_q <= cfg_out_base;
            end
        end
    end

    conv_layer_loop_cnt #(.DIM_W(DIM_W), .NF_W(NF_W), .ADDR_W(ADDR_W)) u_loop (
        .clk          (ACLK),
        .rst          (ARESET),
        .load_i       (state_q == ST_CHECK),
        .step_i       (accept),
        .in_w_i       (in_w_q),
        .out_w_i      (out_w),
        .out_h_i      (out_h),
        .num_filt_i   (num_filt_q),
        .stride_log2_i(stride_q),
        .in_base_i    (in_base_q),
        .out_base_i   (out_base_q),
        .filt_o       (cmd_filt),
        .row_o        (cmd_row),
        .col_o        (cmd_col),
        .in_addr_o    (cmd_in_addr),
        .out_addr_o   (cmd_out_addr),
        .last_o       (last)
    );
endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Sequences the Convolution_Layer datapath for one layer pass. It latches the layer configuration from the S00_AXI register file on a start pulse and validates it. It then walks every output element (filter, row, col), issuing one command per element to the MAC/M00_AXI fetch datapath, with a cap on commands in flight. It reports `busy`, a one-cycle `done` pulse and a sticky error status back to the register file.

## Interface
- `DIM_W`, 10, width of image height/width fields
- `NF_W`, 8, width of filter-count field
- `ADDR_W`, 32, byte-address width (matches M00_AXI)
- `MAX_OUTST`, 4, maximum issued-but-not-completed commands (1..15)

Clock/reset: one clock; reset is synchronous and active-high.
- `ACLK`  in  1  clock
- `ARESET`  in  1  synchronous active-high reset
- `start`  in  1  one-cycle start pulse from register file
- `cfg_in_w`, `cfg_in_h`  in  DIM_W  input feature-map width/height
- `cfg_filt`  in  4  square filter size K
- `cfg_stride_log2`  in  2  stride = 1<<s; legal s = 0..2
- `cfg_num_filt`  in  NF_W  number of filters
- `cfg_in_base`, `cfg_out_base`  in  ADDR_W  byte base addresses
- `cmd_valid`  out  1  command available
- `cmd_ready`  in  1  datapath accepts command
- `cmd_filt`  out  NF_W  filter index
- `cmd_row`, `cmd_col`  out  DIM_W  output coordinates
- `cmd_in_addr`, `cmd_out_addr`  out  ADDR_W  byte addresses
- `dp_done`  in  1  one-cycle completion pulse per command
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle end-of-pass pulse
- `err_cfg`, `err_ovf`  out  1  sticky config error / unexpected completion

## Operation
- States: IDLE, CHECK, ISSUE, DRAIN, DONE.
- In IDLE, `start` latches all `cfg_*` into internal registers, clears both error flags, and moves to CHECK. `start` in any other state is ignored.
- CHECK lasts one cycle. The config is invalid if K==0, K>in_w, K>in_h, num_filt==0, or s==3. Invalid: `err_cfg`=1, go to DONE with no command issued. Valid: compute out_w = ((in_w−K)>>s)+1 and out_h likewise, then go to ISSUE.
- ISSUE loop order: filter outer, row, col inner. The indices advance only on `cmd_valid & cmd_ready`. The acceptance of the last command (f=nf−1, row=out_h−1, col=out_w−1) moves the FSM to DRAIN.
- Address generation is incremental, with no multiplier in the loop:
  - `cmd_in_addr` = in_base + 4·((row<<s)·in_w + (col<<s)).
  - Col step is 4<<s; row step is 4·(in_w<<s). The address returns to in_base at each filter change.
  - `cmd_out_addr` = out_base + 4·idx, where idx is a linear counter incremented per accepted command. Address sums wrap modulo 2^ADDR_W.
- An outstanding counter increments on accept and decrements on `dp_done`. Both in the same cycle leave it unchanged.
- `cmd_valid` = (state==ISSUE) && (outst < MAX_OUTST).
- If `dp_done` arrives while outst==0: set `err_ovf` sticky, keep the counter at 0, and do not stall.
- DRAIN exits to DONE when outst==0. DONE lasts one cycle, asserts `done`, then goes to IDLE.
- Reset mid-pass returns to IDLE immediately. In-flight completions after reset are ignored and set no flags.

## Timing
- Reset values: `cmd_valid`, `busy`, `done`, `err_cfg`, `err_ovf` = 0. All `cmd_*` data = 0; counters = 0.
- Cycle sequence: `start` at cycle N; CHECK at N+1; first `cmd_valid` at N+2 (valid config). On error, `done` at N+2.
- Peak throughput is one command per cycle while `cmd_ready`=1 and under the cap.
- `cmd_*` fields are held stable while `cmd_valid` && !`cmd_ready`. `cmd_valid` never drops without acceptance unless the cap is reached.
- `done` is asserted the cycle after DRAIN sees outst==0. With the last accept in the same cycle as its `dp_done`, the sequence is ISSUE → DRAIN (1 cycle) → DONE.
- `busy` is high from N+1 through the DONE cycle inclusive.

## Structure
- `conv_layer_pkg` holds:
  - the state enum;
  - BYTES_PER_WORD = 4;
  - the stride encoding limits;
  - the config struct (in_w, in_h, filt, stride_log2, num_filt, bases) shared with the S00_AXI register file.
- Sub-module `conv_layer_loop_cnt` implements the three nested counters with wrap/last flags and the incremental in-address. The top contains the FSM, outstanding counter and error flags.

## Test plan
- **Basic pass:** 5×5 input, K=3, s=0, nf=2, in_base=0x1000, out_base=0x8000, `cmd_ready`=1, `dp_done` 1 cycle after each accept. Expect:
  - 18 commands; cmd (f=0,r=1,c=2) in_addr=0x101C, out_addr=0x8014;
  - last cmd out_addr=0x8044;
  - `done` exactly once.
- **Stride 2:** 7×7, K=3, s=1, nf=1, in_base=0. Expect 9 commands; (r=1,c=1) in_addr=0x40; (r=2,c=2) in_addr=0x80.
- **Invalid config:** K=6 with in_w=5. Expect `err_cfg`=1 and `done` at N+2, `cmd_valid` never high, `busy` high only at N+1..N+2.
- **Backpressure and cap:** MAX_OUTST=4, `dp_done` withheld. Expect `cmd_valid` low after 4 accepts. Releasing one `dp_done` allows exactly one more. Random `cmd_ready` stalls keep fields stable.
- **Simultaneous events:**
  - accept plus `dp_done` in one cycle: outst unchanged;
  - `dp_done` with outst=0: `err_ovf`=1, pass still completes;
  - `start` during ISSUE: ignored.
- **Reset mid-ISSUE:** after 5 accepts, assert ARESET for 1 cycle. Expect all outputs 0 next cycle. A following `start` runs a full pass from index 0.
